// File: rtl/mips_pkg.sv
// mips_pkg: EX/MEM and MEM/WB register layouts and MEM-stage FSM states shared across pipeline stages
package mips_pkg;
  localparam int EXMEM_W = 75;
  localparam int MEMWB_W = 71;
  localparam int EX_REGWRITE = 74;
  localparam int EX_MEMWRITE = 73;
  localparam int EX_MEMTOREG = 72;
  localparam int EX_MEMREAD = 71;
  localparam int EX_OVF = 70;
  localparam int EX_ZERO = 69;
  localparam int EX_WREG_LO = 64;
  localparam int EX_SDATA_LO = 32;
  localparam int EX_ALU_LO = 0;
  localparam int WB_ALU_LO = 39;
  localparam int WB_MEMTOREG = 38;
  localparam int WB_REGWRITE = 37;
  localparam int WB_WREG_LO = 32;
  localparam int WB_RESULT_LO = 0;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} mem_state_t;
  typedef struct packed {
    logic        reg_write;
    logic        mem_write;
    logic        mem_to_reg;
    logic        mem_read;
    logic        overflow;
    logic        zero;
    logic [4:0]  write_reg;
    logic [31:0] store_data;
    logic [31:0] alu_result;
  } ex_mem_t;
  typedef struct packed {
    logic [31:0] alu_result;
    logic        mem_to_reg;
    logic        reg_write;
    logic [4:0]  write_reg;
    logic [31:0] wb_result;
  } mem_wb_t;
endpackage

// File: rtl/memory_stage_if.sv
// memory_stage_if: EX/MEM in, MEM/WB out plus stall and exception strobes of the MEM stage
interface memory_stage_if;
  import mips_pkg::*;
  logic [EXMEM_W-1:0] EXMEMReg;
  logic [MEMWB_W-1:0] MEMWBReg;
  logic               memStall;
  logic               ovfException;
  logic               alignErr;
  modport master (output EXMEMReg, input MEMWBReg, memStall, ovfException, alignErr);
  modport slave (input EXMEMReg, output MEMWBReg, memStall, ovfException, alignErr);
endinterface

// File: rtl/data_memory.sv
// data_memory: word-addressed RAM, synchronous write, combinational read, contents not reset
module data_memory #(
  parameter int DEPTH = 256,
  parameter int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);
  logic [31:0] mem [DEPTH];
  always_ff @(posedge clk)
    if (we) mem[addr] <= wdata;
  assign rdata = mem[addr];
endmodule

// File: rtl/memory_stage.sv
// memory_stage: MIPS MEM stage with multi-cycle data-memory access, stall generation and MEM/WB register
module memory_stage import mips_pkg::*; #(
  parameter int DEPTH = 256,
  parameter int MEM_LATENCY = 1
) (
  input  logic           clk,
  input  logic           rst_n,
  memory_stage_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);
  localparam bit SLOW = MEM_LATENCY > 1;
  localparam logic [3:0] LAT = 4'(MEM_LATENCY);
  mem_state_t  state;
  logic [3:0]  cnt;
  ex_mem_t     ex_in, held, cur;
  mem_wb_t     wb_q, nxt;
  logic [31:0] rdata, rd, cap;
  logic        is_mem, latch, we, ovf_q, align_q, unused_zero;
  assign ex_in = ex_mem_t'(bus.EXMEMReg);
  // outside IDLE the stage works from its own copy so upstream may not disturb the access
  assign cur = (state == IDLE) ? ex_in : held;
  assign unused_zero = cur.zero;
  assign is_mem = cur.mem_read | cur.mem_write;
  assign rd = (cur.mem_read & ~cur.mem_write) ? rdata : '0;
  assign we = cur.mem_write & ~cur.overflow &
              ((state == IDLE && !SLOW) || (state == BUSY && cnt == 4'd1));
  assign latch = (state == DONE) || (state == IDLE && !(is_mem && SLOW));
  assign nxt = '{alu_result: cur.alu_result,
                 mem_to_reg: cur.mem_to_reg,
                 reg_write:  cur.reg_write & ~cur.overflow,
                 write_reg:  cur.write_reg,
                 wb_result:  cur.mem_to_reg ? ((state == DONE) ? cap : rd) : cur.alu_result};
  data_memory #(.DEPTH(DEPTH), .AW(AW)) u_ram (
    .clk(clk),
    .we(we),
    .addr(cur.alu_result[AW+1:2]),
    .wdata(cur.store_data),
    .rdata(rdata)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      held    <= '0;
      cap     <= '0;
      wb_q    <= '0;
      ovf_q   <= 1'b0;
      align_q <= 1'b0;
    end else begin
      ovf_q   <= latch & cur.overflow;
      align_q <= latch & is_mem & (cur.alu_result[1:0] != 2'b00);
      if (latch) wb_q <= nxt;
      else wb_q.reg_write <= 1'b0;
      case (state)
        IDLE: if (is_mem && SLOW) begin
          state <= BUSY;
          cnt   <= LAT - 4'd1;
          held  <= ex_in;
        end
        BUSY: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) begin
            state <= DONE;
            cap   <= rd;
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  assign bus.memStall = rst_n & ((state == IDLE && is_mem && SLOW) || state == BUSY);
  assign bus.MEMWBReg = wb_q;
  assign bus.ovfException = ovf_q;
  assign bus.alignErr = align_q;
endmodule

// File: tb/tb_memory_stage.sv
// tb_memory_stage: random and directed MEM-stage traffic on L=1 and L=3 instances against a memory-array model
module tb_memory_stage;
  import mips_pkg::*;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  memory_stage_if b1();
  memory_stage_if b3();
  memory_stage #(.DEPTH(256), .MEM_LATENCY(1)) u_fast (.clk(clk), .rst_n(rst_n), .bus(b1.slave));
  memory_stage #(.DEPTH(256), .MEM_LATENCY(3)) u_slow (.clk(clk), .rst_n(rst_n), .bus(b3.slave));
  int n_checks = 0;
  int n_fail = 0;
  logic [31:0] ref_mem [2][256];
  logic [70:0] last_wb [2];

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [74:0] mk(input logic rw, mw, m2r, mr, ov,
                                     input logic [4:0] wr, input logic [31:0] sd, alu);
    return {rw, mw, m2r, mr, ov, alu == 32'd0, wr, sd, alu};
  endfunction

  function automatic logic [74:0] rand_op();
    logic [31:0] alu;
    logic mr, mw;
    int k;
    k = $urandom_range(3);
    mr = (k == 1) || (k == 3);
    mw = (k >= 2);
    alu = $urandom;
    if ((mr || mw) && $urandom_range(7) != 0) alu[1:0] = 2'b00;
    return mk(1'($urandom_range(1)), mw, 1'($urandom_range(1)), mr, $urandom_range(7) == 0,
              5'($urandom), $urandom, alu);
  endfunction

  task automatic run(input int s, input logic [74:0] ex);
    logic rw, mw, m2r, mr, ov, is_mem;
    logic [4:0] wr;
    logic [31:0] sd, alu, rdv;
    logic [7:0] a;
    logic [70:0] exp_wb;
    int n;
    {rw, mw, m2r, mr, ov} = ex[74:70];
    wr = ex[68:64];
    sd = ex[63:32];
    alu = ex[31:0];
    a = alu[9:2];
    is_mem = mr | mw;
    rdv = (mr && !mw) ? ref_mem[s][a] : 32'd0;
    if (mw && !ov) ref_mem[s][a] = sd;
    exp_wb = {alu, m2r, rw & ~ov, wr, m2r ? rdv : alu};
    if (s == 1) b3.EXMEMReg = ex;
    else b1.EXMEMReg = ex;
    #1;
    n = 0;
    while (((s == 1) ? b3.memStall : b1.memStall) && n < 20) begin
      n++;
      @(posedge clk);
      #1;
      check("bubble", (s == 1) ? b3.MEMWBReg : b1.MEMWBReg, {last_wb[s][70:38], 1'b0, last_wb[s][36:0]});
    end
    check("stall_len", n, (s == 1 && is_mem) ? 3 : 0);
    @(posedge clk);
    #1;
    check("memwb", (s == 1) ? b3.MEMWBReg : b1.MEMWBReg, exp_wb);
    check("ovf", (s == 1) ? b3.ovfException : b1.ovfException, ov);
    check("align", (s == 1) ? b3.alignErr : b1.alignErr, is_mem && alu[1:0] != 2'b00);
    last_wb[s] = exp_wb;
  endtask

  initial begin
    b1.EXMEMReg = '0;
    b3.EXMEMReg = '0;
    last_wb[0] = '0;
    last_wb[1] = '0;
    @(posedge clk);
    #1;
    check("rst_wb", {b1.MEMWBReg, b3.MEMWBReg}, '0);
    check("rst_flags", {b1.memStall, b1.ovfException, b1.alignErr, b3.memStall, b3.ovfException, b3.alignErr}, '0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int s = 0; s < 2; s++) begin
      for (int i = 0; i < 256; i++) run(s, mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, $urandom, 32'(i * 4)));
      run(s, mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd17, 32'd0, 32'd15));
      check("add_result", (s == 1) ? b3.MEMWBReg[37:0] : b1.MEMWBReg[37:0], {1'b1, 5'd17, 32'd15});
      run(s, mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'hDEADBEEF, 32'd100));
      run(s, mk(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 5'd9, 32'd0, 32'd100));
      check("lw_after_sw", (s == 1) ? b3.MEMWBReg[31:0] : b1.MEMWBReg[31:0], 32'hDEADBEEF);
      run(s, mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 5'd3, 32'h55AA55AA, 32'd8));
      run(s, mk(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 5'd4, 32'd0, 32'd8));
      run(s, mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'hCAFEF00D, 32'h406));
      run(s, mk(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 5'd5, 32'd0, 32'd4));
      check("wrap_word1", (s == 1) ? b3.MEMWBReg[31:0] : b1.MEMWBReg[31:0], 32'hCAFEF00D);
      for (int i = 0; i < 300; i++) run(s, rand_op());
    end
    b3.EXMEMReg = mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'h12345678, 32'd20);
    #1;
    check("rst_test_stall1", b3.memStall, 1'b1);
    @(posedge clk);
    #1;
    check("rst_test_stall2", b3.memStall, 1'b1);
    rst_n = 1'b0;
    #1;
    check("midbusy_stall", b3.memStall, 1'b0);
    check("midbusy_wb", {b3.MEMWBReg, b1.MEMWBReg}, '0);
    check("midbusy_flags", {b3.ovfException, b3.alignErr}, '0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    b1.EXMEMReg = '0;
    b3.EXMEMReg = '0;
    rst_n = 1'b1;
    last_wb[0] = '0;
    last_wb[1] = '0;
    run(1, mk(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 5'd6, 32'd0, 32'd20));
    run(0, mk(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 5'd6, 32'd0, 32'd100));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
